// File: rtl/lvds_pkg.sv
// Shared definitions for the A1100 LVDS capture path: state encoding, timing defaults
// and the delay-counter load helper.
package lvds_pkg;

    localparam int unsigned T_RSTA    = 1000;
    localparam int unsigned T_A2D     = 500;
    localparam int unsigned T_SETTLE  = 2000;
    localparam int unsigned DRAIN_TO  = 4096;
    localparam int unsigned FLUSH_LEN = 8;
    localparam int unsigned FRM_W     = 16;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned T_MAX = max_u(max_u(max_u(T_RSTA, T_A2D), max_u(T_SETTLE, DRAIN_TO)),
                                          FLUSH_LEN);
    localparam int unsigned DLY_W = $clog2(T_MAX);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PWR_RST = 3'd1,
        ST_ANA_UP  = 3'd2,
        ST_DIG_UP  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_FLUSH   = 3'd6
    } state_e;

    // Counter value loaded on entry so that the state lasts exactly its nominal cycle count.
    function automatic logic [DLY_W-1:0] dly_load(input state_e s);
        case (s)
            ST_PWR_RST: return DLY_W'(T_RSTA - 1);
            ST_ANA_UP:  return DLY_W'(T_A2D - 1);
            ST_DIG_UP:  return DLY_W'(T_SETTLE - 1);
            ST_DRAIN:   return DLY_W'(DRAIN_TO - 1);
            ST_FLUSH:   return DLY_W'(FLUSH_LEN - 1);
            default:    return '0;
        endcase
    endfunction

endpackage

// File: rtl/lvds_capture_ctrl.sv
// Sensor power-up sequencing, capture gating, frame counting and overflow recovery
// for the A1100 LVDS receive path.
module lvds_capture_ctrl
    import lvds_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [FRM_W-1:0] frame_target,
    input  logic             frame_done,
    input  logic             overflow,
    output logic             rst_a_n,
    output logic             rst_d_n,
    output logic             cap_en,
    output logic             fifo_flush,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [FRM_W-1:0] frame_cnt,
    output logic [2:0]       state_o
);

    state_e           state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [FRM_W-1:0] target_q, target_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             rst_a_q, rst_a_d;
    logic             rst_d_q, rst_d_d;
    logic             cap_en_q, cap_en_d;
    logic             flush_q, flush_d;
    logic             busy_q, busy_d;

    logic             dly_zero;
    logic             cnt_full;
    logic [FRM_W-1:0] frame_inc;
    logic             frame_hit;

    assign dly_zero  = (dly_q == '0);
    assign cnt_full  = &frame_cnt_q;
    assign frame_inc = cnt_full ? frame_cnt_q : frame_cnt_q + FRM_W'(1);
    // A saturated counter can never match a 16-bit target on the next frame.
    assign frame_hit = (target_q != '0) && !cnt_full && (frame_inc == target_q);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dly_q       <= '0;
            target_q    <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            rst_a_q     <= 1'b0;
            rst_d_q     <= 1'b0;
            cap_en_q    <= 1'b0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            target_q    <= target_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
            rst_a_q     <= rst_a_d;
            rst_d_q     <= rst_d_d;
            cap_en_q    <= cap_en_d;
            flush_q     <= flush_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, frame counting and status
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        done_d      = 1'b0;
        dly_d       = dly_zero ? dly_q : dly_q - DLY_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_PWR_RST;
                    target_d    = frame_target;
                    frame_cnt_d = '0;
                    err_d       = 1'b0;
                end
            end
            ST_PWR_RST: begin
                if (stop)          state_d = ST_IDLE;
                else if (dly_zero) state_d = ST_ANA_UP;
            end
            ST_ANA_UP: begin
                if (stop)          state_d = ST_IDLE;
                else if (dly_zero) state_d = ST_DIG_UP;
            end
            ST_DIG_UP: begin
                if (overflow) begin
                    state_d = ST_FLUSH;
                    err_d   = 1'b1;
                end else if (stop) begin
                    state_d = ST_IDLE;
                end else if (dly_zero) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (frame_done) frame_cnt_d = frame_inc;
                if (overflow) begin
                    state_d = ST_FLUSH;
                    err_d   = 1'b1;
                end else if (frame_done && frame_hit) begin
                    state_d = ST_FLUSH;
                    done_d  = 1'b1;
                end else if (stop) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (frame_done) frame_cnt_d = frame_inc;
                if (overflow) begin
                    state_d = ST_FLUSH;
                    err_d   = 1'b1;
                end else if (frame_done) begin
                    state_d = ST_FLUSH;
                    done_d  = 1'b1;
                end else if (dly_zero) begin
                    state_d = ST_FLUSH;
                    err_d   = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (dly_zero) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) dly_d = dly_load(state_d);
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        rst_a_d  = 1'b0;
        rst_d_d  = 1'b0;
        cap_en_d = 1'b0;
        flush_d  = 1'b0;
        busy_d   = (state_d != ST_IDLE);

        case (state_d)
            ST_ANA_UP: rst_a_d = 1'b1;
            ST_DIG_UP, ST_DRAIN: begin
                rst_a_d = 1'b1;
                rst_d_d = 1'b1;
            end
            ST_CAPTURE: begin
                rst_a_d  = 1'b1;
                rst_d_d  = 1'b1;
                cap_en_d = 1'b1;
            end
            ST_FLUSH: begin
                rst_a_d = rst_a_q;
                rst_d_d = rst_d_q;
                flush_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign rst_a_n    = rst_a_q;
    assign rst_d_n    = rst_d_q;
    assign cap_en     = cap_en_q;
    assign fifo_flush = flush_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign frame_cnt  = frame_cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_lvds_capture_ctrl.sv
// Scoreboard bench: each scenario predicts the cycle-stamped output changes it should
// cause; an independent monitor pops and compares them whenever the DUT outputs change.
`timescale 1ns/1ps
module tb_lvds_capture_ctrl;

    localparam int unsigned FW  = 16;
    localparam int unsigned TA  = 1000;
    localparam int unsigned TAD = 500;
    localparam int unsigned TS  = 2000;
    localparam int unsigned TDR = 4096;
    localparam int unsigned TFL = 8;
    localparam int unsigned NEVER = 32'hFFFF_FFFF;
    localparam logic [2:0] S_IDLE = 3'd0, S_PWR = 3'd1, S_ANA = 3'd2, S_DIG = 3'd3,
                           S_CAP = 3'd4, S_DRN = 3'd5, S_FLS = 3'd6;

    logic          clk = 1'b0, rst_n = 1'b1;
    logic          start = 1'b0, stop = 1'b0, frame_done = 1'b0, overflow = 1'b0;
    logic [FW-1:0] frame_target = '0;
    logic          rst_a_n, rst_d_n, cap_en, fifo_flush, busy, done, err;
    logic [FW-1:0] frame_cnt;
    logic [2:0]    state_o;

    lvds_capture_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .frame_target(frame_target), .frame_done(frame_done), .overflow(overflow),
        .rst_a_n(rst_a_n), .rst_d_n(rst_d_n), .cap_en(cap_en), .fifo_flush(fifo_flush),
        .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rst_a_n, rst_d_n, cap_en, fifo_flush, busy, done, err;
        logic [FW-1:0] frame_cnt;
        logic [2:0]    state;
    } obs_t;

    typedef struct {
        int unsigned t;
        obs_t        o;
    } ev_t;

    ev_t         exp_q[$];
    obs_t        mcur, mlast, mon_prev;
    int unsigned cyc = 0;
    int unsigned n_chk = 0, n_pass = 0;
    logic        mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t cur_obs();
        return '{rst_a_n, rst_d_n, cap_en, fifo_flush, busy, done, err, frame_cnt, state_o};
    endfunction

    // Monitor: every output change must match the oldest predicted change, in time and value
    always @(negedge clk) begin
        obs_t c;
        ev_t  e;
        if (mon_en) begin
            c = cur_obs();
            if (c !== mon_prev) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change cyc=%0d actual=%h required=no change", cyc, c);
                end else begin
                    e = exp_q.pop_front();
                    if (e.t == cyc && e.o === c) n_pass++;
                    else $display("FAIL output_event actual cyc=%0d obs=%h required cyc=%0d obs=%h",
                                  cyc, c, e.t, e.o);
                end
                mon_prev = c;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push(input int unsigned t);
        ev_t e;
        if (mcur != mlast) begin
            e.t = t;
            e.o = mcur;
            exp_q.push_back(e);
            mlast = mcur;
        end
    endtask

    task automatic inc_cnt();
        if (mcur.frame_cnt != '1) mcur.frame_cnt = mcur.frame_cnt + FW'(1);
    endtask

    task automatic goto(input int unsigned k);
        while (cyc < k) @(negedge clk);
    endtask

    // Inputs set here are sampled by the DUT at posedge number k
    task automatic drive(input int unsigned k, input logic st, input logic sp,
                         input logic fd, input logic ov);
        goto(k - 1);
        start = st; stop = sp; frame_done = fd; overflow = ov;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; frame_done = 1'b0; overflow = 1'b0;
    endtask

    task automatic do_start(input logic [FW-1:0] tgt, output int unsigned s);
        drive(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0);
        s = cyc + 1 + $urandom_range(0, 3);
        mcur.state = S_PWR; mcur.busy = 1'b1; mcur.frame_cnt = '0; mcur.err = 1'b0;
        push(s);
        frame_target = tgt;
        drive(s, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        frame_target = FW'($urandom);
    endtask

    task automatic model_powerup(input int unsigned s, input int unsigned upto);
        if (s + TA < upto) begin
            mcur.state = S_ANA; mcur.rst_a_n = 1'b1; push(s + TA);
        end
        if (s + TA + TAD < upto) begin
            mcur.state = S_DIG; mcur.rst_d_n = 1'b1; push(s + TA + TAD);
        end
        if (s + TA + TAD + TS < upto) begin
            mcur.state = S_CAP; mcur.cap_en = 1'b1; push(s + TA + TAD + TS);
        end
    endtask

    task automatic model_to_flush(input int unsigned t, input logic dn, input logic er);
        mcur.state = S_FLS; mcur.cap_en = 1'b0; mcur.fifo_flush = 1'b1; mcur.done = dn;
        if (er) mcur.err = 1'b1;
        push(t);
        if (dn) begin
            mcur.done = 1'b0; push(t + 1);
        end
        mcur.state = S_IDLE; mcur.busy = 1'b0; mcur.fifo_flush = 1'b0;
        mcur.rst_a_n = 1'b0; mcur.rst_d_n = 1'b0;
        push(t + TFL);
    endtask

    task automatic cap_frames(input int unsigned n, inout int unsigned t);
        for (int i = 0; i < int'(n); i++) begin
            t += $urandom_range(1, 40);
            inc_cnt(); push(t);
            drive(t, 1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic sc_count(input int unsigned tgt);
        int unsigned s, t;
        logic sp;
        do_start(FW'(tgt), s);
        model_powerup(s, NEVER);
        drive(s + 1200, 1'b1, 1'b0, 1'b1, 1'b0);
        t = s + TA + TAD + TS;
        cap_frames(tgt - 1, t);
        t += $urandom_range(1, 40);
        sp = 1'($urandom_range(0, 1));
        inc_cnt();
        model_to_flush(t, 1'b1, 1'b0);
        drive(t, 1'b0, sp, 1'b1, 1'b0);
        drive(t + 3, 1'b1, 1'b1, 1'b1, 1'b1);
        goto(t + TFL + 2);
    endtask

    task automatic sc_stop(input int unsigned tgt, input int unsigned nfr, input logic co,
                           input int unsigned gap, input logic tmo);
        int unsigned s, t, p;
        do_start(FW'(tgt), s);
        model_powerup(s, NEVER);
        t = s + TA + TAD + TS;
        cap_frames(nfr, t);
        p = t + $urandom_range(1, 40);
        if (co) inc_cnt();
        mcur.state = S_DRN; mcur.cap_en = 1'b0; push(p);
        drive(p, 1'b0, 1'b1, co, 1'b0);
        if (tmo) begin
            model_to_flush(p + TDR, 1'b0, 1'b1);
            drive(p + 1, 1'b1, 1'b0, 1'b0, 1'b0);
            goto(p + TDR + TFL + 2);
        end else begin
            inc_cnt();
            model_to_flush(p + gap, 1'b1, 1'b0);
            if (gap > 1) drive(p + 1, 1'b1, 1'b0, 1'b0, 1'b0);
            drive(p + gap, 1'b0, 1'b0, 1'b1, 1'b0);
            goto(p + gap + TFL + 2);
        end
    endtask

    task automatic sc_ovf(input logic in_dig, input int unsigned tgt, input int unsigned k,
                          input logic co, input logic sp);
        int unsigned s, t, o;
        do_start(FW'(tgt), s);
        if (in_dig) begin
            o = s + TA + TAD + 1 + $urandom_range(0, TS - 1);
            model_powerup(s, o);
        end else begin
            model_powerup(s, NEVER);
            t = s + TA + TAD + TS;
            cap_frames(k, t);
            o = t + $urandom_range(1, 40);
            if (co) inc_cnt();
        end
        model_to_flush(o, 1'b0, 1'b1);
        drive(o, 1'b0, sp, co, 1'b1);
        goto(o + TFL + 2);
    endtask

    task automatic sc_abort(input int unsigned ph, input logic fd);
        int unsigned s, a;
        do_start(FW'($urandom_range(0, 9)), s);
        case (ph)
            0:       a = s + 1 + $urandom_range(0, TA - 1);
            1:       a = s + TA + 1 + $urandom_range(0, TAD - 1);
            default: a = s + TA + TAD + 1 + $urandom_range(0, TS - 1);
        endcase
        model_powerup(s, a);
        mcur.state = S_IDLE; mcur.busy = 1'b0; mcur.cap_en = 1'b0;
        mcur.rst_a_n = 1'b0; mcur.rst_d_n = 1'b0;
        push(a);
        drive(a, 1'b0, 1'b1, fd, 1'b0);
        goto(a + 3);
    endtask

    task automatic sc_areset(input int unsigned k);
        int unsigned s, t, r;
        do_start(FW'(0), s);
        model_powerup(s, NEVER);
        t = s + TA + TAD + TS;
        cap_frames(k, t);
        r = t + $urandom_range(5, 50);
        goto(r - 1);
        mcur = '0;
        push(r);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (cur_obs() === obs_t'('0)) n_pass++;
        else $display("FAIL async_reset actual=%h required=%h", cur_obs(), obs_t'('0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        mcur = '0; mlast = '0; mon_prev = '0;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (cur_obs() === obs_t'('0)) n_pass++;
        else $display("FAIL reset_state actual=%h required=%h", cur_obs(), obs_t'('0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        sc_count(3);
        sc_stop(0, 2, 1'b0, 100, 1'b0);
        sc_stop(0, 1, 1'b0, 0, 1'b1);
        sc_ovf(1'b0, 0, 1, 1'b1, 1'b0);
        sc_abort(1, 1'b0);
        sc_areset(1);
        sc_count(1);

        for (int i = 0; i < 6; i++) begin
            int unsigned kind, k;
            kind = $urandom_range(0, 4);
            k    = $urandom_range(0, 2);
            case (kind)
                0: sc_count($urandom_range(1, 4));
                1: sc_stop(($urandom_range(0, 1) != 0) ? 0 : 50, $urandom_range(0, 3),
                           1'($urandom_range(0, 1)), $urandom_range(1, 150),
                           $urandom_range(0, 4) == 0);
                2: sc_ovf(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 1) != 0) ? 0 : k + 1 + $urandom_range(0, 2),
                          k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                3: sc_abort($urandom_range(0, 2), 1'($urandom_range(0, 1)));
                default: sc_areset(k);
            endcase
        end

        goto(cyc + 20);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL pending_events actual=%0d required=0 (next at cyc %0d)",
                      exp_q.size(), exp_q[0].t);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
